// File: rtl/pll_supervisor_pkg.sv
// rtl/pll_supervisor_pkg.sv - state encodings and shared widths for the PLL reset sequencer
package pll_supervisor_pkg;

  localparam int RETRY_W = 3;
  localparam logic [RETRY_W-1:0] RETRY_SAT = 3'd7;

  typedef logic [2:0] state_t;

  localparam state_t ST_PRST      = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_SETTLE    = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_supervisor_sync2.sv
// rtl/pll_supervisor_sync2.sv - generic two-flop synchronizer, async active-low reset to 0
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// rtl/pll_supervisor.sv - PLL reset pulse, lock timeout/retry, settle window and core reset release
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned        RST_CYCLES    = 16,
  parameter int unsigned        LOCK_TIMEOUT  = 65535,
  parameter int unsigned        SETTLE_CYCLES = 1024,
  parameter logic [RETRY_W-1:0] MAX_RETRY     = 3'd7
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               soft_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first settle cycle.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
      CNT_W'((SETTLE_CYCLES > 1) ? (SETTLE_CYCLES - 2) : 0);
  localparam bit SETTLE_BYPASS = (SETTLE_CYCLES <= 1);

  logic               locked_s;
  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RETRY_W-1:0] retry_d, retry_inc;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clock (clock),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    retry_inc = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + 1'b1;
    state_d   = state;
    retry_d   = retry_cnt;

    case (state)
      ST_PRST: begin
        if (cnt == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = SETTLE_BYPASS ? ST_RUN : ST_SETTLE;
        end else if (cnt == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc > MAX_RETRY) ? ST_FAULT : ST_PRST;
        end
      end
      ST_SETTLE: begin
        if (!locked_s)               state_d = ST_WAIT_LOCK;
        else if (cnt == SETTLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) state_d = ST_PRST;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_PRST;
      end
    endcase

    if (soft_req) begin
      state_d = ST_PRST;
      retry_d = '0;
    end
    if (state_d == ST_RUN) retry_d = '0;

    // Shared counter restarts on any state change and saturates instead of wrapping.
    if (soft_req || (state_d != state)) cnt_d = '0;
    else if (&cnt)                       cnt_d = cnt;
    else                                 cnt_d = cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PRST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      retry_cnt <= retry_d;
      pll_rst   <= (state_d == ST_PRST) || (state_d == ST_FAULT);
      sys_rst_n <= (state_d == ST_RUN);
      ready     <= (state_d == ST_RUN);
      fault     <= (state_d == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// tb/tb_pll_supervisor.sv - self-checking bench for pll_supervisor against a deadline-based model
module tb_pll_supervisor;

  localparam int RST_C = 4;
  localparam int SET_C = 8;
  localparam int TMO_C = 32;
  localparam int MAXR  = 2;
  localparam int LIMIT = 200;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       soft_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [2:0] retry_cnt;

  int checks = 0;
  int failures = 0;

  pll_supervisor #(
    .RST_CYCLES    (RST_C),
    .LOCK_TIMEOUT  (TMO_C),
    .SETTLE_CYCLES (SET_C),
    .MAX_RETRY     (3'd2)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .locked    (locked),
    .soft_req  (soft_req),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt)
  );

  always #10 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases with entry timestamps; exits happen at absolute deadlines.
  typedef enum int {M_PRST, M_WAIT, M_SETTLE, M_RUN, M_FAULT} mphase_e;
  mphase_e ph = M_PRST;
  int      cyc = 0;
  int      t_in = 0;
  int      m_retry = 0;
  logic    s1 = 1'b0, s2 = 1'b0, m_ls;

  task automatic enter(input mphase_e p);
    ph   = p;
    t_in = cyc;
  endtask

  function automatic logic [6:0] model_outs();
    return {(ph == M_PRST) || (ph == M_FAULT), ph == M_RUN, ph == M_RUN, ph == M_FAULT,
            m_retry[2:0]};
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (!rst_n) begin
      ph = M_PRST; t_in = cyc; m_retry = 0; s1 = 1'b0; s2 = 1'b0;
    end else begin
      m_ls = s2; s2 = s1; s1 = locked;
      if (soft_req) begin
        enter(M_PRST);
        m_retry = 0;
      end else begin
        case (ph)
          M_PRST:   if (cyc == t_in + RST_C) enter(M_WAIT);
          M_WAIT: begin
            if (m_ls) enter(M_SETTLE);
            else if (cyc == t_in + TMO_C) begin
              m_retry = (m_retry >= 7) ? 7 : m_retry + 1;
              enter((m_retry > MAXR) ? M_FAULT : M_PRST);
            end
          end
          M_SETTLE: begin
            if (!m_ls) enter(M_WAIT);
            else if (cyc == t_in + SET_C - 1) enter(M_RUN);
          end
          M_RUN:    if (!m_ls) enter(M_PRST);
          default:  ;
        endcase
      end
      if (ph == M_RUN) m_retry = 0;
    end
    #1;
    check_eq("cycle_outs", {25'd0, pll_rst, sys_rst_n, ready, fault, retry_cnt},
             {25'd0, model_outs()});
  end

  function automatic logic sig(input int s);
    case (s)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return ready;
      3:       return fault;
      default: return 1'b0;
    endcase
  endfunction

  task automatic edges_until(input int s, input logic v, output int n);
    n = 0;
    while ((sig(s) !== v) && (n < LIMIT)) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= LIMIT) check_eq("wait_bound", {31'd0, sig(s)}, {31'd0, v});
  endtask

  initial begin
    int n;
    int r;
    repeat (3) @(negedge clock);
    check_eq("reset_outs", {pll_rst, sys_rst_n, ready, fault, retry_cnt}, 7'b1000000);

    // Nominal lock
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && (n < LIMIT)) begin n++; @(negedge clock); end
    check_eq("nom_prst_width", n, RST_C);
    repeat (6) @(negedge clock);
    locked = 1'b1;
    edges_until(2, 1'b1, n);
    check_eq("nom_lock_to_ready", n, SET_C + 2);
    check_eq("nom_sys_rst_n", sys_rst_n, 1);
    check_eq("nom_retry", retry_cnt, 0);

    // Loss of lock in RUN
    @(negedge clock);
    locked = 1'b0;
    edges_until(1, 1'b0, n);
    check_eq("loss_latency", n, 3);
    check_eq("loss_pll_rst", pll_rst, 1);
    edges_until(0, 1'b0, n);
    check_eq("loss_prst_width", n, RST_C);
    @(negedge clock);
    locked = 1'b1;
    edges_until(2, 1'b1, n);
    check_eq("relock_latency", n, SET_C + 2);

    // Never lock: retries then FAULT
    @(negedge clock);
    locked = 1'b0;
    soft_req = 1'b1;
    @(posedge clock); #1;
    soft_req = 1'b0;
    check_eq("soft_enters_prst", pll_rst, 1);
    edges_until(0, 1'b0, n);
    check_eq("soft_prst_width", n, RST_C);
    for (int i = 1; i <= 2; i++) begin
      edges_until(0, 1'b1, n);
      check_eq("retry_gap", n, TMO_C);
      check_eq("retry_step", retry_cnt, i);
      edges_until(0, 1'b0, n);
      check_eq("retry_prst_width", n, RST_C);
    end
    edges_until(3, 1'b1, n);
    check_eq("fault_gap", n, TMO_C);
    check_eq("fault_retry", retry_cnt, 3);
    repeat (40) @(posedge clock);
    #1;
    check_eq("fault_hold", {fault, pll_rst, sys_rst_n}, 3'b110);

    @(negedge clock);
    soft_req = 1'b1;
    @(posedge clock); #1;
    soft_req = 1'b0;
    check_eq("fault_exit", {fault, pll_rst, retry_cnt}, 5'b01000);
    edges_until(0, 1'b0, n);
    check_eq("fault_exit_prst_width", n, RST_C);

    // Glitch during SETTLE with one retry on record
    edges_until(0, 1'b1, n);
    check_eq("glitch_pre_retry", retry_cnt, 1);
    edges_until(0, 1'b0, n);
    @(negedge clock);
    locked = 1'b1;
    repeat ($urandom_range(2, 5)) @(negedge clock);
    locked = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("glitch_no_run", ready, 0);
    check_eq("glitch_retry_kept", retry_cnt, 1);
    locked = 1'b1;
    edges_until(2, 1'b1, n);
    check_eq("glitch_fresh_settle", n, SET_C + 2);
    check_eq("run_clears_retry", retry_cnt, 0);

    // soft_req on the same cycle as a FAULT-producing timeout
    @(negedge clock);
    locked = 1'b0;
    edges_until(1, 1'b0, n);
    edges_until(0, 1'b0, n);
    for (int i = 0; i < 2; i++) begin
      edges_until(0, 1'b1, n);
      edges_until(0, 1'b0, n);
    end
    check_eq("prio_pre_retry", retry_cnt, 2);
    repeat (TMO_C - 1) @(posedge clock);
    @(negedge clock);
    soft_req = 1'b1;
    @(posedge clock); #1;
    soft_req = 1'b0;
    check_eq("prio_soft_wins", {fault, pll_rst, retry_cnt}, 5'b01000);

    // Asynchronous reset in the middle of SETTLE
    edges_until(0, 1'b0, n);
    @(negedge clock);
    locked = 1'b1;
    repeat (6) @(negedge clock);
    check_eq("midseq_pre_pll_rst", pll_rst, 0);
    #5 rst_n = 1'b0;
    #1 check_eq("midseq_reset", {pll_rst, sys_rst_n, ready, fault, retry_cnt}, 7'b1000000);
    @(negedge clock);
    rst_n = 1'b1;
    edges_until(2, 1'b1, n);
    check_eq("post_reset_lock", n, RST_C + SET_C);

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      @(negedge clock);
      if (r < 4) begin
        soft_req = 1'b1;
        @(negedge clock);
        soft_req = 1'b0;
      end else if (r < 6) begin
        #5 rst_n = 1'b0;
        #1 check_eq("rand_async_rst", {pll_rst, sys_rst_n, ready, fault, retry_cnt},
                    7'b1000000);
        @(negedge clock);
        rst_n = 1'b1;
      end else begin
        locked = ~locked;
        repeat ($urandom_range(1, 45)) @(negedge clock);
      end
    end

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
